seq_magnitude_comparator: RTL and testbench

Multi-cycle unsigned magnitude comparator for operands wider than one nibble. It scans A and B four bits per clock, most-significant nibble first, and stops at the first nibble that differs. It sits upstream of the cascaded 4-bit comparison logic: it produces the same one-hot LT/EQ/GT result, but serially, with a start/done handshake.

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/seq_magnitude_comparator_if.sv | 26 ++
 rtl/seq_magnitude_comparator_nibble_cmp.sv | 16 +
 rtl/seq_magnitude_comparator.sv | 109 ++++++++++
 tb/tb_seq_magnitude_comparator.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM states,
// nibble width and the one-hot {LT, EQ, GT} result encoding.
package cmp_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Bit order is {LT, EQ, GT}
    typedef logic [2:0] result_t;

    localparam result_t RES_NONE = 3'b000;
    localparam result_t RES_LT   = 3'b100;
    localparam result_t RES_EQ   = 3'b010;
    localparam result_t RES_GT   = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Start/done handshake bundle between a requester (master) and the
// serial comparator (slave).
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16
) ();

    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic             LT_OUT;
    logic             EQ_OUT;
    logic             GT_OUT;

    modport master (
        output START, A, B,
        input  BUSY, DONE, LT_OUT, EQ_OUT, GT_OUT
    );

    modport slave (
        input  START, A, B,
        output BUSY, DONE, LT_OUT, EQ_OUT, GT_OUT
    );

endinterface

// File: rtl/seq_magnitude_comparator_nibble_cmp.sv
// Purely combinational unsigned comparison of two 4-bit values.
module nibble_cmp
    import cmp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    output logic                o_lt,
    output logic                o_eq,
    output logic                o_gt
);

    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Serial unsigned magnitude comparator: walks A and B one nibble per clock,
// most-significant first, and stops at the first nibble that differs.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    seq_magnitude_comparator_if.slave bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    // Keep the counter at least one bit wide so WIDTH=4 still elaborates
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    result_t          r_res;
    result_t          w_res_next;

    logic             w_lt;
    logic             w_eq;
    logic             w_gt;

    // Only the top nibble of each shift register is ever compared
    nibble_cmp u_nibble_cmp (
        .i_a  (r_a[WIDTH-1 -: NIBBLE_W]),
        .i_b  (r_b[WIDTH-1 -: NIBBLE_W]),
        .o_lt (w_lt),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    // State, shift registers, counter and result; reset aborts everything
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_res   <= RES_NONE;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_cnt   <= w_cnt_next;
            r_res   <= w_res_next;
        end
    end

    // Next-state and datapath updates; START is only honoured outside RUN
    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_cnt_next   = r_cnt;
        w_res_next   = r_res;

        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (bus.START) begin
                    w_a_next     = bus.A;
                    w_b_next     = bus.B;
                    w_cnt_next   = CNT_W'(NIBBLES - 1);
                    w_res_next   = RES_NONE;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (w_gt) begin
                    w_res_next   = RES_GT;
                    w_state_next = ST_FIN;
                end else if (w_lt) begin
                    w_res_next   = RES_LT;
                    w_state_next = ST_FIN;
                end else if (w_eq && (r_cnt == '0)) begin
                    w_res_next   = RES_EQ;
                    w_state_next = ST_FIN;
                end else begin
                    w_a_next     = r_a << NIBBLE_W;
                    w_b_next     = r_b << NIBBLE_W;
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // All outputs come straight from registers
    assign bus.BUSY   = (r_state == ST_RUN);
    assign bus.DONE   = (r_state == ST_FIN);
    assign bus.LT_OUT = r_res[2];
    assign bus.EQ_OUT = r_res[1];
    assign bus.GT_OUT = r_res[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for the serial magnitude comparator (WIDTH=16).
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 16;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_LT   = 3'b100;
    localparam logic [2:0] R_EQ   = 3'b010;
    localparam logic [2:0] R_GT   = 3'b001;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

    seq_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] res_now();
        return {bus.LT_OUT, bus.EQ_OUT, bus.GT_OUT};
    endfunction

    function automatic logic [4:0] outs_now();
        return {bus.BUSY, bus.DONE, bus.LT_OUT, bus.EQ_OUT, bus.GT_OUT};
    endfunction

    // Called at a negedge; START is sampled on the following posedge
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    // Counts BUSY cycles until DONE; mode 1 scrambles A/B mid-run,
    // mode 2 raises START during the 2nd RUN cycle. Returns at the DONE cycle.
    task automatic observe(input string tag, input int k, input logic [2:0] exp_res, input int mode);
        int busy_cnt = 0;
        bit done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.DONE) begin
                done_seen = 1;
                break;
            end
            if (bus.BUSY) busy_cnt++;
            if (mode == 1 && busy_cnt == 1) begin
                bus.A = '0;
                bus.B = '0;
            end
            if (mode == 2) bus.START = (busy_cnt == 2);
            @(negedge clk);
        end
        bus.START = 1'b0;
        check({tag, " done"}, 32'(done_seen), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(k));
        check({tag, " result"}, 32'(res_now()), 32'(exp_res));
        $display("[TB] %s: busy=%0d result=%b", tag, busy_cnt, res_now());
    endtask

    // One cycle after DONE: pulse gone, back in IDLE, result held
    task automatic post_check(input string tag, input logic [2:0] exp_res);
        @(negedge clk);
        check({tag, " post"}, 32'(outs_now()), 32'({2'b00, exp_res}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stray;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        check("reset outs", 32'(outs_now()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'h1234, 16'h1234); observe("eq_1234", 4, R_EQ, 0); post_check("eq_1234", R_EQ);
        launch(16'h9000, 16'h1FFF); observe("gt_9000", 1, R_GT, 0); post_check("gt_9000", R_GT);
        launch(16'h1230, 16'h1231); observe("lt_lsb",  4, R_LT, 0); post_check("lt_lsb",  R_LT);
        launch(16'hFFFF, 16'h0000); observe("gt_ffff", 1, R_GT, 0); post_check("gt_ffff", R_GT);
        launch(16'h00FF, 16'h00FE); observe("ab_change", 4, R_GT, 1); post_check("ab_change", R_GT);

        // Second START during RUN must be ignored: no extra op afterwards
        launch(16'h1234, 16'h1235); observe("start_in_run", 4, R_LT, 2); post_check("start_in_run", R_LT);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.BUSY || bus.DONE) stray = 1;
        end
        check("start_in_run no_extra", 32'(stray), 32'd0);

        // Reset in the 2nd RUN cycle: outputs clear before any clock edge
        launch(16'h1234, 16'h1234);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset outs", 32'(outs_now()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (outs_now() != 5'd0) stray = 1;
        end
        check("after reset no_done", 32'(stray), 32'd0);
        launch(16'h0001, 16'h0002); observe("lt_after_rst", 4, R_LT, 0); post_check("lt_after_rst", R_LT);

        // Back-to-back: START during FIN, next BUSY with no idle cycle
        launch(16'h5000, 16'h4000); observe("b2b_first", 1, R_GT, 0);
        launch(16'h0000, 16'h0000);
        check("b2b busy_done", 32'({bus.BUSY, bus.DONE}), 32'(2'b10));
        check("b2b cleared", 32'(res_now()), 32'(R_NONE));
        observe("b2b_second", 4, R_EQ, 0); post_check("b2b_second", R_EQ);

        // Result holds across idle cycles, clears on the next accepted START
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (outs_now() != {2'b00, R_EQ}) stray = 1;
        end
        check("hold 10 idle", 32'(stray), 32'd0);
        launch(16'h8000, 16'h7000);
        check("clear on start", 32'(res_now()), 32'(R_NONE));
        observe("gt_8000", 1, R_GT, 0); post_check("gt_8000", R_GT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
